// File: rtl/keypad_pkg.sv
// Shared types, sentinels and the physical key map for the 4x4 hex keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {
    S_DRIVE  = 2'd0,
    S_SAMPLE = 2'd1,
    S_EVAL   = 2'd2
  } scan_state_t;

  // Scan results are 5 bits wide: a hex key in [3:0], or this sentinel for "no single key".
  localparam logic [4:0] KEY_NONE = 5'h10;

  // Entry [4*row+col] is the legend printed on that key; col 0 is the leftmost column.
  localparam logic [15:0][3:0] KEY_MAP = {
    4'hD, 4'hE, 4'hF, 4'h0,   // row 3
    4'hC, 4'h9, 4'h8, 4'h7,   // row 2
    4'hB, 4'h6, 4'h5, 4'h4,   // row 1
    4'hA, 4'h3, 4'h2, 4'h1    // row 0
  };

  // Chords and ghost images both show up as two or more closed contacts; all collapse to NONE.
  function automatic logic [4:0] scan_decode(input logic [15:0] closed);
    logic [4:0] hits;
    logic [4:0] key;
    hits = '0;
    key  = KEY_NONE;
    for (int i = 0; i < 16; i++) begin
      if (closed[i[3:0]]) begin
        hits = hits + 5'd1;
        key  = {1'b0, KEY_MAP[i[3:0]]};
      end
    end
    return (hits == 5'd1) ? key : KEY_NONE;
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Debounce and one-shot event generation on full-scan results.
// Optional auto-repeat is built only when KEYPAD_REPEAT_EN is defined.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_SCANS   = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       strobe,
  input  logic [4:0] result,
  output logic       accept,
  output logic [3:0] accept_key,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int            CW        = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CW-1:0] COUNT_MAX = CW'(DEBOUNCE_SCANS);

  logic [4:0]    cand_q, cand_d;
  logic [CW-1:0] count_q, count_d;
  logic          held_d;
  logic          same;
  logic          becomes;
  logic          repeat_due;

  // NOTE: every signal driven here gets a default first, so no path leaves one unassigned
  // and no latch is inferred.
  always_comb begin
    same    = (result == cand_q);
    cand_d  = cand_q;
    count_d = count_q;
    becomes = 1'b0;
    if (strobe) begin
      if (same) begin
        count_d = (count_q == COUNT_MAX) ? count_q : count_q + 1'b1;
      end else begin
        cand_d  = result;
        count_d = CW'(1);
      end
      // Only the scan on which the count reaches the limit counts as a decision.
      becomes = (count_d == COUNT_MAX) && (!same || count_q != COUNT_MAX);
    end
  end

`ifdef KEYPAD_REPEAT_EN
  localparam int RW = $clog2(REPEAT_SCANS + 1);

  logic [RW-1:0] rep_q, rep_d;

  always_comb begin
    rep_d      = rep_q;
    repeat_due = 1'b0;
    if (strobe) begin
      if (!same || becomes) begin
        rep_d = '0;
      end else if (key_held && cand_q == {1'b0, key_code}) begin
        if (rep_q == RW'(REPEAT_SCANS - 1)) begin
          repeat_due = 1'b1;
          rep_d      = '0;
        end else begin
          rep_d = rep_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rep_q <= '0;
    else     rep_q <= rep_d;
  end
`else
  localparam int UNUSED_REPEAT_SCANS = REPEAT_SCANS;
  assign repeat_due = 1'b0;
`endif

  always_comb begin
    held_d     = key_held;
    accept     = 1'b0;
    accept_key = result[3:0];
    if (becomes) begin
      if (result == KEY_NONE) begin
        held_d = 1'b0;
      end else begin
        held_d = 1'b1;
        // A still-held key that merely bounced back does not fire again; a new key does.
        if (!key_held || result[3:0] != key_code) accept = 1'b1;
      end
    end else if (repeat_due) begin
      accept = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      cand_q    <= KEY_NONE;
      count_q   <= '0;
      key_held  <= 1'b0;
      key_code  <= '0;
      key_valid <= 1'b0;
    end else begin
      cand_q    <= cand_d;
      count_q   <= count_d;
      key_held  <= held_d;
      key_valid <= accept;
      if (accept) key_code <= accept_key;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 hex keypad scanner: row drive FSM, column synchronizer, debounce and 16-bit entry value.
// Define KEYPAD_REPEAT_EN to build the auto-repeat feature.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 1000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_SCANS   = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic [3:0]  col,
  output logic [3:0]  row,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic        key_held,
  output logic [15:0] value
);

  localparam int SW = $clog2(SETTLE_CYCLES);

  scan_state_t   state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [15:0]   scan_q, scan_d;
  logic [3:0]    col_meta, col_sync;
  logic          accept;
  logic [3:0]    accept_key;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    settle_d = settle_q;
    scan_d   = scan_q;
    case (state_q)
      S_DRIVE: begin
        if (settle_q == SW'(SETTLE_CYCLES - 1)) begin
          settle_d = '0;
          state_d  = S_SAMPLE;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      S_SAMPLE: begin
        // Columns are active-low: a closed contact becomes a 1 in the scan image.
        scan_d[4*idx_q +: 4] = ~col_sync;
        idx_d   = idx_q + 1'b1;
        state_d = (idx_q == 2'd3) ? S_EVAL : S_DRIVE;
      end
      S_EVAL:  state_d = S_DRIVE;
      default: state_d = S_DRIVE;
    endcase
  end

  // NOTE: the scan image is an ordinary register, reset so an interrupted scan leaves no residue.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_DRIVE;
      idx_q    <= '0;
      settle_q <= '0;
      scan_q   <= '0;
      row      <= 4'b1110;
      col_meta <= 4'hF;
      col_sync <= 4'hF;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      settle_q <= settle_d;
      scan_q   <= scan_d;
      row      <= ~(4'b0001 << idx_d);
      col_meta <= col;
      col_sync <= col_meta;
    end
  end

  keypad_debounce #(
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS),
    .REPEAT_SCANS  (REPEAT_SCANS)
  ) u_debounce (
    .clk       (clk),
    .rst       (rst),
    .strobe    (state_q == S_EVAL),
    .result    (scan_decode(scan_q)),
    .accept    (accept),
    .accept_key(accept_key),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  // clear outranks a same-cycle digit entry.
  always_ff @(posedge clk) begin
    if (rst)         value <= '0;
    else if (clear)  value <= '0;
    else if (accept) value <= {value[11:0], accept_key};
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: a per-scan behavioural model predicts key events,
// a monitor checks each key_valid pulse against them.
`timescale 1ns/1ps
module tb_keypad_scanner;

  localparam int SETTLE = 3;
  localparam int DEB    = 2;
  localparam int REP    = 3;
  localparam logic [4:0] NONE = 5'h10;
  // Key legend by physical position, row-major, column 0 leftmost.
  localparam logic [3:0] POS_KEY [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                          4'h4, 4'h5, 4'h6, 4'hB,
                                          4'h7, 4'h8, 4'h9, 4'hC,
                                          4'h0, 4'hF, 4'hE, 4'hD};

  typedef struct {
    logic [3:0]  key;
    logic [15:0] val;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic [3:0]  col;
  logic [3:0]  row;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [15:0] value;
  logic [15:0] pressed;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   pulses   = 0;
  int   cycle    = 0;
  exp_t sb[$];

  // Model state
  logic [4:0]  last_res = NONE;
  int          run      = 0;
  bit          m_held   = 1'b0;
  logic [3:0]  m_key    = '0;
  logic [15:0] m_val    = '0;
  int          last_end = -1;
  int          scan_no  = 0;

  keypad_scanner #(
    .SETTLE_CYCLES (SETTLE),
    .DEBOUNCE_SCANS(DEB),
    .REPEAT_SCANS  (REP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .col      (col),
    .row      (row),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held),
    .value    (value)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  // Passive switch matrix: a pressed key shorts its column to its row.
  always_comb begin
    col = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!row[r] && pressed[4*r+c]) col[c] = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      check("row_one_low", {28'd0, row} inside {4'b1110, 4'b1101, 4'b1011, 4'b0111}, 1);
      if (key_valid) begin
        pulses++;
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL spurious_key_valid: got pulse key %0h value %0h, expected none",
                   key_code, value);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("event_key_code", {28'd0, key_code}, {28'd0, e.key});
          check("event_value", {16'd0, value}, {16'd0, e.val});
        end
      end
    end
  end

  function automatic int pos_of(input logic [3:0] k);
    for (int i = 0; i < 16; i++) if (POS_KEY[i] == k) return i;
    return 0;
  endfunction

  function automatic logic [15:0] key_mask(input logic [3:0] k);
    return 16'd1 << pos_of(k);
  endfunction

  function automatic logic [4:0] ref_result(input logic [15:0] mask);
    if ($countones(mask) != 1) return NONE;
    for (int i = 0; i < 16; i++) if (mask[i]) return {1'b0, POS_KEY[i]};
    return NONE;
  endfunction

  // Returns in the evaluation cycle that follows the last row's sample.
  task automatic wait_scan_end();
    logic [3:0] prev;
    prev = row;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (prev == 4'b0111 && row == 4'b1110) return;
      prev = row;
    end
    check("scan_end_timeout", 1, 0);
  endtask

  // One full scan with a fixed set of closed keys; optionally pulse clear in the decision cycle.
  task automatic scan(input logic [15:0] mask, input bit do_clear);
    logic [4:0] res;
    bit ev;
    pressed = mask;
    wait_scan_end();
    scan_no++;
    if (scan_no == 2) check("scan_period", cycle - last_end, 17);
    last_end = cycle;
    res = ref_result(mask);
    if (res == last_res) run++;
    else begin
      last_res = res;
      run = 1;
    end
    ev = 1'b0;
    if (run == DEB) begin
      if (res[4]) m_held = 1'b0;
      else begin
        if (!m_held || res[3:0] != m_key) ev = 1'b1;
        m_held = 1'b1;
        m_key  = res[3:0];
      end
    end
`ifdef KEYPAD_REPEAT_EN
    else if (run > DEB && m_held && !res[4] && res[3:0] == m_key && (run - DEB) % REP == 0)
      ev = 1'b1;
`endif
    if (do_clear) m_val = '0;
    else if (ev)  m_val = {m_val[11:0], res[3:0]};
    if (ev) sb.push_back('{res[3:0], m_val});
    clear = do_clear;
    @(negedge clk);
    clear = 1'b0;
    check("key_held", {31'd0, key_held}, {31'd0, m_held});
  endtask

  task automatic press(input logic [3:0] k, input int hold, input int rel);
    for (int i = 0; i < hold; i++) scan(key_mask(k), 1'b0);
    for (int i = 0; i < rel; i++) scan('0, 1'b0);
  endtask

  initial begin
    int p0;
    rst = 1'b1;
    clear = 1'b0;
    pressed = '0;
    repeat (2) @(negedge clk);
    check("reset_row", {28'd0, row}, 32'hE);
    check("reset_value", {16'd0, value}, 0);
    check("reset_key_valid", {31'd0, key_valid}, 0);
    check("reset_key_held", {31'd0, key_held}, 0);
    check("reset_key_code", {28'd0, key_code}, 0);
    rst = 1'b0;

    scan('0, 1'b0);
    scan('0, 1'b0);

    p0 = pulses;
    press(4'h5, 4, 0);
    check("press5_pulses", pulses - p0, 1);
    check("press5_code", {28'd0, key_code}, 5);
    check("press5_value", {16'd0, value}, 16'h0005);
    check("press5_held", {31'd0, key_held}, 1);
    scan('0, 1'b0);
    scan('0, 1'b0);
    check("release_held", {31'd0, key_held}, 0);

    press(4'h1, 3, 2);
    press(4'h2, 3, 2);
    press(4'hA, 3, 2);
    press(4'hF, 3, 2);
    check("value_12AF", {16'd0, value}, 16'h12AF);
    press(4'h3, 3, 2);
    check("value_2AF3", {16'd0, value}, 16'h2AF3);

    p0 = pulses;
    for (int i = 0; i < 10; i++) scan(i % 2 == 0 ? key_mask(4'h8) : 16'h0, 1'b0);
    scan('0, 1'b0);
    check("bounce_pulses", pulses - p0, 0);
    check("bounce_value", {16'd0, value}, 16'h2AF3);

    p0 = pulses;
    for (int i = 0; i < 4; i++) scan(key_mask(4'h5) | key_mask(4'h6), 1'b0);
    scan('0, 1'b0);
    scan('0, 1'b0);
    check("ghost_pulses", pulses - p0, 0);

    p0 = pulses;
    scan(key_mask(4'h7), 1'b0);
    scan(key_mask(4'h7), 1'b1);
    scan('0, 1'b0);
    scan('0, 1'b0);
    check("clear7_pulses", pulses - p0, 1);
    check("clear7_value", {16'd0, value}, 0);
    check("clear7_code", {28'd0, key_code}, 7);

    p0 = pulses;
    press(4'h1, 3, 0);
    press(4'h9, 3, 2);
    check("direct_change_pulses", pulses - p0, 2);
    check("direct_change_value", {16'd0, value}, 16'h0019);

    for (int it = 0; it < 24; it++) begin
      logic [15:0] m;
      int hold;
      m = 16'd1 << $urandom_range(0, 15);
      if ($urandom_range(0, 3) == 0) m = m | (16'd1 << $urandom_range(0, 15));
      hold = $urandom_range(1, 5);
      for (int i = 0; i < hold; i++) scan(m, 1'b0);
      scan('0, $urandom_range(0, 4) == 0);
      scan('0, 1'b0);
      if ($urandom_range(0, 1) == 1) scan('0, 1'b0);
    end
    check("random_value", {16'd0, value}, {16'd0, m_val});

    scan('0, 1'b1);
    scan('0, 1'b0);
    p0 = pulses;
    press(4'hC, 11, 2);
`ifdef KEYPAD_REPEAT_EN
    check("hold_C_pulses", pulses - p0, 4);
    check("hold_C_value", {16'd0, value}, 16'hCCCC);
`else
    check("hold_C_pulses", pulses - p0, 1);
    check("hold_C_value", {16'd0, value}, 16'h000C);
`endif

    repeat (4) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
